// File: rtl/fetch_pkg.sv
// Shared types and defaults for the dual-issue fetch redirect controller.
// Contents: controller state enum, reset/increment defaults, slot encoding,
// registered pulse bundle and the sequential-PC helper.
package fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT    = 32'hbfc0_0000;
  localparam int unsigned       FETCH_BYTES_DEFAULT = 8;

  // jr_slot encoding: which issue slot holds the JR/JALR
  localparam logic SLOT_1 = 1'b0;
  localparam logic SLOT_2 = 1'b1;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_JRWAIT = 2'd2
  } fetch_state_e;

  // Single-cycle control pulses towards ID and the redirect requesters
  typedef struct packed {
    logic flush;
    logic kill;
    logic ack;
  } fetch_pulse_t;

  // Next sequential fetch address; wraps modulo 2^ADDR_W
  function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc,
                                               input int unsigned        step);
    return pc + ADDR_W'(step);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Redirect / stall event counter pair, present only when FETCH_PERF_CNT_EN
// is defined.
// Ports: clk, reset (async active-low), redir_evt, stall_evt (one count per
// cycle each), redir_cnt, stall_cnt (free-running, wrap at 2^32).
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             redir_evt,
  input  logic             stall_evt,
  output logic [CNT_W-1:0] redir_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redir_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (redir_evt) redir_cnt <= redir_cnt + CNT_W'(1);
      if (stall_evt) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer for the dual-issue IF stage. Arbitrates exception,
// slot-1/slot-2 branch and JR redirects against hard/soft stalls and emits
// squash pulses for the pair entering ID.
// Ports: clk, reset (async active-low); stall_hard, stall_soft; exc_req/exc_pc;
// br1_req/br1_target, br2_req/br2_target, jr_req/jr_slot/jr_data/jr_data_ok;
// outputs fetch_pc, fetch_valid, flush_id, kill_slot2, redir_ack, jr_wait.
// Optional: FETCH_PERF_CNT_EN adds perf_redir_cnt and perf_stall_cnt.
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned       FETCH_BYTES = FETCH_BYTES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_hard,
  input  logic              stall_soft,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              br1_req,
  input  logic [ADDR_W-1:0] br1_target,
  input  logic              br2_req,
  input  logic [ADDR_W-1:0] br2_target,
  input  logic              jr_req,
  input  logic              jr_slot,
  input  logic [ADDR_W-1:0] jr_data,
  input  logic              jr_data_ok,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_valid,
  output logic              flush_id,
  output logic              kill_slot2,
  output logic              redir_ack,
  output logic              jr_wait
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_redir_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  fetch_pulse_t      pulse_q, pulse_d;
  logic              jr_wait_q, jr_wait_d;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      pulse_q   <= '0;
      jr_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      pulse_q   <= pulse_d;
      jr_wait_q <= jr_wait_d;
    end
  end

  // Redirect arbitration and next-state; pulses default low every edge
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    pulse_d = '0;

    if (exc_req) begin
      // Exceptions win over stalls and an outstanding JR wait; never acked
      state_d       = ST_RUN;
      pc_d          = exc_pc;
      valid_d       = 1'b1;
      pulse_d.flush = 1'b1;
    end else if (!stall_hard) begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
          valid_d = 1'b1;
        end
        ST_RUN: begin
          if (br1_req) begin
            // Also covers a simultaneous br2_req (younger, squashed)
            pc_d          = br1_target;
            pulse_d.flush = 1'b1;
            pulse_d.ack   = 1'b1;
          end else if (jr_req) begin
            pulse_d.ack = 1'b1;
            if (jr_slot == SLOT_2) pulse_d.kill  = 1'b1;
            else                   pulse_d.flush = 1'b1;
            if (jr_data_ok) begin
              pc_d = jr_data;
            end else begin
              // Target not ready: stop fetching until the register arrives
              valid_d = 1'b0;
              state_d = ST_JRWAIT;
            end
          end else if (br2_req) begin
            // Slot 1 is the delay slot of the slot-2 branch and survives
            pc_d         = br2_target;
            pulse_d.kill = 1'b1;
            pulse_d.ack  = 1'b1;
          end else if (stall_soft) begin
            pulse_d.flush = 1'b1;
          end else begin
            pc_d = seq_pc(pc_q, FETCH_BYTES);
          end
        end
        ST_JRWAIT: begin
          if (jr_data_ok) begin
            pc_d    = jr_data;
            valid_d = 1'b1;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end

    jr_wait_d = (state_d == ST_JRWAIT);
  end

  assign fetch_pc    = pc_q;
  assign fetch_valid = valid_q;
  assign flush_id    = pulse_q.flush;
  assign kill_slot2  = pulse_q.kill;
  assign redir_ack   = pulse_q.ack;
  assign jr_wait     = jr_wait_q;

`ifdef FETCH_PERF_CNT_EN
  // Count redirects at the edge they are taken; stalls include JR wait cycles
  logic redir_evt_c;
  logic stall_evt_c;

  assign redir_evt_c = pulse_d.ack | exc_req;
  assign stall_evt_c = stall_hard | stall_soft | jr_wait_q;

  fetch_perf_cnt u_perf_cnt (
    .clk       (clk),
    .reset     (reset),
    .redir_evt (redir_evt_c),
    .stall_evt (stall_evt_c),
    .redir_cnt (perf_redir_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: a directed vector table for the
// documented sequences, then randomized requests against a reference model.
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  // Vector input flags
  localparam logic [7:0] F_EXC  = 8'h80;
  localparam logic [7:0] F_BR1  = 8'h40;
  localparam logic [7:0] F_BR2  = 8'h20;
  localparam logic [7:0] F_JR   = 8'h10;
  localparam logic [7:0] F_S2   = 8'h08;
  localparam logic [7:0] F_OK   = 8'h04;
  localparam logic [7:0] F_HARD = 8'h02;
  localparam logic [7:0] F_SOFT = 8'h01;
  // Expected output flags {valid, flush, kill, ack, jr_wait}
  localparam logic [4:0] E_V  = 5'h10;
  localparam logic [4:0] E_FL = 5'h08;
  localparam logic [4:0] E_K  = 5'h04;
  localparam logic [4:0] E_A  = 5'h02;
  localparam logic [4:0] E_W  = 5'h01;

  typedef struct packed {
    logic [7:0]  fl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_pc;
    logic [4:0]  e_fl;
  } vec_t;

  logic        clk, reset;
  logic        stall_hard, stall_soft, exc_req, br1_req, br2_req, jr_req, jr_slot, jr_data_ok;
  logic [31:0] exc_pc, br1_target, br2_target, jr_data;
  logic [31:0] fetch_pc;
  logic        fetch_valid, flush_id, kill_slot2, redir_ack, jr_wait;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redir_cnt, perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  fetch_redirect_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall_hard  (stall_hard),
    .stall_soft  (stall_soft),
    .exc_req     (exc_req),
    .exc_pc      (exc_pc),
    .br1_req     (br1_req),
    .br1_target  (br1_target),
    .br2_req     (br2_req),
    .br2_target  (br2_target),
    .jr_req      (jr_req),
    .jr_slot     (jr_slot),
    .jr_data     (jr_data),
    .jr_data_ok  (jr_data_ok),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .flush_id    (flush_id),
    .kill_slot2  (kill_slot2),
    .redir_ack   (redir_ack),
    .jr_wait     (jr_wait)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redir_cnt (perf_redir_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic [4:0] e_fl);
    check({tag, " pc"},      fetch_pc,             e_pc);
    check({tag, " valid"},   32'(fetch_valid),     32'(e_fl[4]));
    check({tag, " flush"},   32'(flush_id),        32'(e_fl[3]));
    check({tag, " kill"},    32'(kill_slot2),      32'(e_fl[2]));
    check({tag, " ack"},     32'(redir_ack),       32'(e_fl[1]));
    check({tag, " jr_wait"}, 32'(jr_wait),         32'(e_fl[0]));
  endtask

  task automatic drive(input logic [7:0] fl, input logic [31:0] a, input logic [31:0] b);
    exc_req    = fl[7];  exc_pc     = a;
    br1_req    = fl[6];  br1_target = a;
    br2_req    = fl[5];  br2_target = fl[6] ? b : a;
    jr_req     = fl[4];  jr_slot    = fl[3];
    jr_data_ok = fl[2];  jr_data    = a;
    stall_hard = fl[1];  stall_soft = fl[0];
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic        m_valid, m_flush, m_kill, m_ack, m_jrw;
  bit          m_booted, m_waiting;
  logic [31:0] m_rcnt, m_scnt;

  function automatic void model_reset();
    m_pc = RST_PC; m_valid = 0; m_flush = 0; m_kill = 0; m_ack = 0; m_jrw = 0;
    m_booted = 0; m_waiting = 0; m_rcnt = 0; m_scnt = 0;
  endfunction

  // Effect of one clock edge given the inputs currently applied
  function automatic void model_step();
    bit counted_stall;
    counted_stall = stall_hard || stall_soft || m_jrw;
    m_flush = 0; m_kill = 0; m_ack = 0;
    if (exc_req) begin
      m_pc = exc_pc; m_flush = 1; m_valid = 1; m_booted = 1; m_waiting = 0;
    end else if (stall_hard) begin
      // frozen
    end else if (!m_booted) begin
      m_booted = 1; m_valid = 1;
    end else if (m_waiting) begin
      if (jr_data_ok) begin m_pc = jr_data; m_valid = 1; m_waiting = 0; end
    end else if (br1_req) begin
      m_pc = br1_target; m_flush = 1; m_ack = 1;
    end else if (jr_req) begin
      m_ack = 1;
      if (jr_slot) m_kill = 1; else m_flush = 1;
      if (jr_data_ok) m_pc = jr_data;
      else begin m_valid = 0; m_waiting = 1; end
    end else if (br2_req) begin
      m_pc = br2_target; m_kill = 1; m_ack = 1;
    end else if (stall_soft) begin
      m_flush = 1;
    end else begin
      m_pc = 32'((64'(m_pc) + 64'd8) % 64'h1_0000_0000);
    end
    m_jrw = m_waiting;
    if (m_ack || exc_req) m_rcnt = m_rcnt + 1;
    if (counted_stall)    m_scnt = m_scnt + 1;
  endfunction

  function automatic logic [4:0] model_flags();
    return {m_valid, m_flush, m_kill, m_ack, m_jrw};
  endfunction

  task automatic check_model(input string tag);
    check_outs(tag, m_pc, model_flags());
`ifdef FETCH_PERF_CNT_EN
    check({tag, " perf_redir"}, perf_redir_cnt, m_rcnt);
    check({tag, " perf_stall"}, perf_stall_cnt, m_scnt);
`endif
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[28];

  bit          p_br1, p_br2, p_jr, p_slot;
  logic [31:0] p_br1_t, p_br2_t;

  initial begin
    tbl[0]  = '{8'h00,            32'h0,        32'h0,   32'hbfc0_0000, E_V};
    tbl[1]  = '{8'h00,            32'h0,        32'h0,   32'hbfc0_0008, E_V};
    tbl[2]  = '{8'h00,            32'h0,        32'h0,   32'hbfc0_0010, E_V};
    tbl[3]  = '{F_BR2,            32'h8000_1000, 32'h0,  32'h8000_1000, E_V | E_K | E_A};
    tbl[4]  = '{8'h00,            32'h0,        32'h0,   32'h8000_1008, E_V};
    tbl[5]  = '{F_BR1 | F_BR2,    32'h100,      32'h200, 32'h100,       E_V | E_FL | E_A};
    tbl[6]  = '{8'h00,            32'h0,        32'h0,   32'h108,       E_V};
    tbl[7]  = '{F_JR,             32'h0,        32'h0,   32'h108,       E_FL | E_A | E_W};
    tbl[8]  = '{8'h00,            32'h0,        32'h0,   32'h108,       E_W};
    tbl[9]  = '{8'h00,            32'h0,        32'h0,   32'h108,       E_W};
    tbl[10] = '{F_OK,             32'h8000_2000, 32'h0,  32'h8000_2000, E_V};
    tbl[11] = '{8'h00,            32'h0,        32'h0,   32'h8000_2008, E_V};
    tbl[12] = '{F_BR1 | F_HARD,   32'h300,      32'h0,   32'h8000_2008, E_V};
    tbl[13] = '{F_BR1 | F_HARD,   32'h300,      32'h0,   32'h8000_2008, E_V};
    tbl[14] = '{F_BR1,            32'h300,      32'h0,   32'h300,       E_V | E_FL | E_A};
    tbl[15] = '{8'h00,            32'h0,        32'h0,   32'h308,       E_V};
    tbl[16] = '{F_EXC | F_HARD,   32'h180,      32'h0,   32'h180,       E_V | E_FL};
    tbl[17] = '{8'h00,            32'h0,        32'h0,   32'h188,       E_V};
    tbl[18] = '{F_BR1,            32'hffff_fff8, 32'h0,  32'hffff_fff8, E_V | E_FL | E_A};
    tbl[19] = '{8'h00,            32'h0,        32'h0,   32'h0,         E_V};
    tbl[20] = '{F_SOFT,           32'h0,        32'h0,   32'h0,         E_V | E_FL};
    tbl[21] = '{8'h00,            32'h0,        32'h0,   32'h8,         E_V};
    tbl[22] = '{F_JR | F_S2 | F_OK, 32'h4000,   32'h0,   32'h4000,      E_V | E_K | E_A};
    tbl[23] = '{8'h00,            32'h0,        32'h0,   32'h4008,      E_V};
    tbl[24] = '{F_JR | F_S2,      32'h0,        32'h0,   32'h4008,      E_K | E_A | E_W};
    tbl[25] = '{F_EXC,            32'h500,      32'h0,   32'h500,       E_V | E_FL};
    tbl[26] = '{F_SOFT | F_BR2,   32'h600,      32'h0,   32'h600,       E_V | E_K | E_A};
    tbl[27] = '{8'h00,            32'h0,        32'h0,   32'h608,       E_V};

    // Reset state
    reset = 1'b0;
    drive(8'h00, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", RST_PC, 5'h00);
    reset = 1'b1;

    // Directed vectors, applied on consecutive edges
    foreach (tbl[i]) begin
      drive(tbl[i].fl, tbl[i].a, tbl[i].b);
      @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_fl);
    end

    // Randomized phase against the model, with periodic async resets
    reset = 1'b0;
    drive(8'h00, 32'h0, 32'h0);
    #1;
    model_reset();
    check_model("rnd reset0");
    @(negedge clk);
    reset = 1'b1;
    p_br1 = 0; p_br2 = 0; p_jr = 0; p_slot = 0; p_br1_t = 0; p_br2_t = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 699) begin
        reset = 1'b0;
        #1;
        model_reset();
        p_br1 = 0; p_br2 = 0; p_jr = 0;
        check_model($sformatf("rnd reset%0d", cyc));
        @(negedge clk);
        reset = 1'b1;
      end
      // Requesters hold a request until it is acked or flushed by an exception
      if (!p_br1 && $urandom_range(7) == 0) begin p_br1 = 1; p_br1_t = $urandom; end
      if (!p_br2 && $urandom_range(7) == 0) begin p_br2 = 1; p_br2_t = $urandom; end
      if (!p_jr  && $urandom_range(9) == 0) begin p_jr  = 1; p_slot  = 1'($urandom_range(1)); end
      br1_req    = p_br1;  br1_target = p_br1_t;
      br2_req    = p_br2;  br2_target = p_br2_t;
      jr_req     = p_jr;   jr_slot    = p_slot;
      jr_data    = $urandom;
      jr_data_ok = ($urandom_range(2) == 0);
      exc_req    = ($urandom_range(19) == 0);
      exc_pc     = $urandom;
      stall_hard = ($urandom_range(5) == 0);
      stall_soft = ($urandom_range(5) == 0);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_model($sformatf("rnd%0d", cyc));
      if (m_ack || exc_req) begin p_br1 = 0; p_br2 = 0; p_jr = 0; end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
